// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch slice: the fetch FSM state
// type, the halt opcode and the default address/instruction widths.
package fetch_pkg;

   // Default program-counter / memory-address width (64-word memory).
   localparam int FETCH_ADDR_W  = 6;
   // Default instruction width.
   localparam int FETCH_INSTR_W = 16;

   // Upper seven instruction bits that identify a halt word.
   localparam logic [6:0] HALT_OPCODE = 7'b1111000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_halt_detect.sv
// fetch_halt_detect
// Combinational halt-word recogniser. Compares the opcode field of the
// word currently read from instruction memory against HALT_OPCODE.
// Ports:
//   opcode  in  7  upper seven bits of the memory read data
//   is_halt out 1  high when opcode is the halt opcode
module fetch_halt_detect
   import fetch_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       is_halt
);

   assign is_halt = (opcode == HALT_OPCODE);

endmodule : fetch_halt_detect

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller. Owns the program counter, drives the
// combinational instruction-memory read address, captures each fetched word
// into a single-entry valid/ready slot for decode, applies branch redirects
// and, when FETCH_HALT_DETECT_EN is defined, stops fetching after a halt word.
// Without FETCH_HALT_DETECT_EN the halt word is an ordinary instruction,
// DRAIN/HALTED are never entered and halted stays 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             pulse: leave IDLE and fetch from address 0
//   imem_addr         memory read address (equals pc)
//   imem_data         memory read data, valid in the same cycle
//   instr_out/pc      registered word and the address it came from
//   instr_valid/ready slot handshake with decode
//   redirect/target   taken branch from execute, replaces pc
//   busy, halted      status: fetching/draining, stopped after halt
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int INSTR_W = FETCH_INSTR_W
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               busy,
   output logic               halted
);

   fetch_state_e       state_r,       state_nxt_s;
   logic [ADDR_W-1:0]  pc_r,          pc_nxt_s;
   logic [INSTR_W-1:0] instr_out_r,   instr_out_nxt_s;
   logic [ADDR_W-1:0]  instr_pc_r,    instr_pc_nxt_s;
   logic               instr_valid_r, instr_valid_nxt_s;
   logic               busy_r,        busy_nxt_s;
   logic               halted_r,      halted_nxt_s;
   logic               slot_free_s;
   logic               halt_s;

`ifdef FETCH_HALT_DETECT_EN
   fetch_halt_detect u_halt_detect (
      .opcode  (imem_data[INSTR_W-1 -: 7]),
      .is_halt (halt_s)
   );
`else
   assign halt_s = 1'b0;
`endif

   // The slot can take a new word when empty or when decode takes the current one.
   assign slot_free_s = ~instr_valid_r | instr_ready;

   // Next-state, pc and output-slot logic for the fetch FSM.
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      instr_out_nxt_s   = instr_out_r;
      instr_pc_nxt_s    = instr_pc_r;
      instr_valid_nxt_s = instr_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_FETCH;
               pc_nxt_s    = {ADDR_W{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // Redirect wins over capture: the presented word is younger than the branch.
            if (redirect) begin
               pc_nxt_s          = redirect_target;
               instr_valid_nxt_s = 1'b0;
               state_nxt_s       = ST_FETCH;
            end else if (slot_free_s) begin
               instr_out_nxt_s   = imem_data;
               instr_pc_nxt_s    = pc_r;
               instr_valid_nxt_s = 1'b1;
               // Wraps modulo 2^ADDR_W by width truncation.
               pc_nxt_s          = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               if (halt_s) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            // Only the halt word is in flight; wait for decode to take it.
            if (redirect) begin
               pc_nxt_s          = redirect_target;
               instr_valid_nxt_s = 1'b0;
               state_nxt_s       = ST_FETCH;
            end else if (instr_valid_r && instr_ready) begin
               instr_valid_nxt_s = 1'b0;
               state_nxt_s       = ST_HALTED;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_HALTED: begin
            state_nxt_s = ST_HALTED;
         end
         default: begin
            state_nxt_s       = ST_IDLE;
            pc_nxt_s          = {ADDR_W{1'b0}};
            instr_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Status flags are derived from the next state so they are registered with it.
   always_comb begin
`ifdef FETCH_HALT_DETECT_EN
      busy_nxt_s   = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DRAIN);
      halted_nxt_s = (state_nxt_s == ST_HALTED);
`else
      busy_nxt_s   = (state_nxt_s != ST_IDLE);
      halted_nxt_s = 1'b0;
`endif
   end

   // State, pc, output slot and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         pc_r          <= {ADDR_W{1'b0}};
         instr_out_r   <= {INSTR_W{1'b0}};
         instr_pc_r    <= {ADDR_W{1'b0}};
         instr_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         instr_out_r   <= instr_out_nxt_s;
         instr_pc_r    <= instr_pc_nxt_s;
         instr_valid_r <= instr_valid_nxt_s;
         busy_r        <= busy_nxt_s;
         halted_r      <= halted_nxt_s;
      end
   end

   assign imem_addr   = pc_r;
   assign instr_out   = instr_out_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;
   assign busy        = busy_r;
   assign halted      = halted_r;

endmodule : fetch_sequencer
